// File: rtl/msf_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : msf_time_keeper
//  Purpose  : Local time-of-day keeper fed by the MSF time/date decoder.
//             Loads decoded hh:mm on a valid frame, free-runs a BCD hh:mm:ss
//             clock from the 1 Hz second strobe, realigns seconds on each
//             minute marker (absorbing leap seconds) and tracks sync status
//             (UNSYNC / LOCKED / HOLDOVER).
//  Ports    :
//    clk_i, rst_i            clock, synchronous active-high reset
//    tick_i, second_00_i     second strobe, minute-marker qualifier
//    load_i, load_*_i        decoded-frame valid and BCD hh:mm digits
//    hour_*_o .. second_*_o  BCD time of day
//    locked_o, holdover_o,
//    time_valid_o            sync status
//    update_o, reject_o      one-cycle strobes (time changed / load dropped)
//  Revision : 1.0  initial release
// ============================================================================
module msf_time_keeper #(
    parameter int unsigned HOLDOVER_MINUTES = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       second_00_i,
    input  logic       load_i,
    input  logic [1:0] load_hour_h_i,
    input  logic [3:0] load_hour_l_i,
    input  logic [2:0] load_minute_h_i,
    input  logic [3:0] load_minute_l_i,
    output logic [1:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [2:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic [2:0] second_h_o,
    output logic [3:0] second_l_o,
    output logic       locked_o,
    output logic       holdover_o,
    output logic       time_valid_o,
    output logic       update_o,
    output logic       reject_o
);

    localparam logic [1:0] c_ST_UNSYNC   = 2'd0;
    localparam logic [1:0] c_ST_LOCKED   = 2'd1;
    localparam logic [1:0] c_ST_HOLDOVER = 2'd2;

    localparam logic [7:0] c_MISS_HOLD = 8'd2;
    localparam logic [7:0] c_MISS_DROP = 8'(HOLDOVER_MINUTES + 1);
    localparam logic [7:0] c_MISS_MAX  = 8'hFF;

    // Registered state
    logic [1:0] r_hh_h;
    logic [3:0] r_hh_l;
    logic [2:0] r_mm_h;
    logic [3:0] r_mm_l;
    logic [2:0] r_ss_h;
    logic [3:0] r_ss_l;
    logic [1:0] r_state;
    logic [7:0] r_miss;
    logic       r_locked;
    logic       r_holdover;
    logic       r_valid;
    logic       r_update;
    logic       r_reject;

    // Next-state values
    logic       w_load_ok;
    logic       w_accept;
    logic       w_reject;
    logic       w_tick;
    logic       w_min_evt;
    logic       w_hr_evt;
    logic [1:0] w_hh_h_nxt;
    logic [3:0] w_hh_l_nxt;
    logic [2:0] w_mm_h_nxt;
    logic [3:0] w_mm_l_nxt;
    logic [2:0] w_ss_h_nxt;
    logic [3:0] w_ss_l_nxt;
    logic [7:0] w_miss_nxt;
    logic [1:0] w_state_nxt;
    logic       w_changed;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_load_ok = (load_hour_h_i <= 2'd2) && (load_hour_l_i <= 4'd9) &&
                    !((load_hour_h_i == 2'd2) && (load_hour_l_i > 4'd3)) &&
                    (load_minute_h_i <= 3'd5) && (load_minute_l_i <= 4'd9);
        w_accept  = load_i && w_load_ok;
        w_reject  = load_i && !w_load_ok;
        // Any load owns the cycle: a coincident tick is dropped. This also
        // keeps update_o and reject_o mutually exclusive.
        w_tick    = tick_i && !load_i;

        w_ss_h_nxt = r_ss_h;
        w_ss_l_nxt = r_ss_l;
        w_mm_h_nxt = r_mm_h;
        w_mm_l_nxt = r_mm_l;
        w_hh_h_nxt = r_hh_h;
        w_hh_l_nxt = r_hh_l;
        w_min_evt  = 1'b0;
        w_hr_evt   = 1'b0;

        // Seconds. The marker forces :00; it only counts as a new minute
        // when the second count was in its upper half, so a leap second that
        // already rolled 59->00 (or an early spurious marker) adds nothing.
        if (w_tick) begin
            if (second_00_i) begin
                w_ss_h_nxt = 3'd0;
                w_ss_l_nxt = 4'd0;
                w_min_evt  = (r_ss_h >= 3'd3);
            end else if (r_ss_l == 4'd9) begin
                w_ss_l_nxt = 4'd0;
                if (r_ss_h == 3'd5) begin
                    w_ss_h_nxt = 3'd0;
                    w_min_evt  = 1'b1;
                end else begin
                    w_ss_h_nxt = r_ss_h + 3'd1;
                end
            end else begin
                w_ss_l_nxt = r_ss_l + 4'd1;
            end
        end

        // Minutes
        if (w_min_evt) begin
            if (r_mm_l == 4'd9) begin
                w_mm_l_nxt = 4'd0;
                if (r_mm_h == 3'd5) begin
                    w_mm_h_nxt = 3'd0;
                    w_hr_evt   = 1'b1;
                end else begin
                    w_mm_h_nxt = r_mm_h + 3'd1;
                end
            end else begin
                w_mm_l_nxt = r_mm_l + 4'd1;
            end
        end

        // Hours, silent day wrap at 23 -> 00
        if (w_hr_evt) begin
            if ((r_hh_h == 2'd2) && (r_hh_l == 4'd3)) begin
                w_hh_h_nxt = 2'd0;
                w_hh_l_nxt = 4'd0;
            end else if (r_hh_l == 4'd9) begin
                w_hh_l_nxt = 4'd0;
                w_hh_h_nxt = r_hh_h + 2'd1;
            end else begin
                w_hh_l_nxt = r_hh_l + 4'd1;
            end
        end

        // Minutes seen since the last good frame, saturating
        w_miss_nxt = r_miss;
        if (w_min_evt && (r_miss != c_MISS_MAX)) begin
            w_miss_nxt = r_miss + 8'd1;
        end

        // Status FSM, evaluated on the post-increment miss count so the
        // status moves on the same edge as the minute boundary.
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOCKED: begin
                if (w_miss_nxt >= c_MISS_HOLD) begin
                    w_state_nxt = c_ST_HOLDOVER;
                end
            end
            c_ST_HOLDOVER: begin
                if (w_miss_nxt >= c_MISS_DROP) begin
                    w_state_nxt = c_ST_UNSYNC;
                end
            end
            default: begin
                w_state_nxt = c_ST_UNSYNC;
            end
        endcase

        if (w_accept) begin
            w_hh_h_nxt  = load_hour_h_i;
            w_hh_l_nxt  = load_hour_l_i;
            w_mm_h_nxt  = load_minute_h_i;
            w_mm_l_nxt  = load_minute_l_i;
            w_ss_h_nxt  = 3'd0;
            w_ss_l_nxt  = 4'd0;
            w_miss_nxt  = 8'd0;
            w_state_nxt = c_ST_LOCKED;
        end

        w_changed = {w_hh_h_nxt, w_hh_l_nxt, w_mm_h_nxt, w_mm_l_nxt, w_ss_h_nxt, w_ss_l_nxt} !=
                    {r_hh_h, r_hh_l, r_mm_h, r_mm_l, r_ss_h, r_ss_l};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hh_h     <= 2'd0;
            r_hh_l     <= 4'd0;
            r_mm_h     <= 3'd0;
            r_mm_l     <= 4'd0;
            r_ss_h     <= 3'd0;
            r_ss_l     <= 4'd0;
            r_state    <= c_ST_UNSYNC;
            r_miss     <= 8'd0;
            r_locked   <= 1'b0;
            r_holdover <= 1'b0;
            r_valid    <= 1'b0;
            r_update   <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_hh_h     <= w_hh_h_nxt;
            r_hh_l     <= w_hh_l_nxt;
            r_mm_h     <= w_mm_h_nxt;
            r_mm_l     <= w_mm_l_nxt;
            r_ss_h     <= w_ss_h_nxt;
            r_ss_l     <= w_ss_l_nxt;
            r_state    <= w_state_nxt;
            r_miss     <= w_miss_nxt;
            r_locked   <= (w_state_nxt == c_ST_LOCKED);
            r_holdover <= (w_state_nxt == c_ST_HOLDOVER);
            r_valid    <= (w_state_nxt == c_ST_LOCKED) || (w_state_nxt == c_ST_HOLDOVER);
            r_update   <= w_changed;
            r_reject   <= w_reject;
        end
    end

    assign hour_h_o     = r_hh_h;
    assign hour_l_o     = r_hh_l;
    assign minute_h_o   = r_mm_h;
    assign minute_l_o   = r_mm_l;
    assign second_h_o   = r_ss_h;
    assign second_l_o   = r_ss_l;
    assign locked_o     = r_locked;
    assign holdover_o   = r_holdover;
    assign time_valid_o = r_valid;
    assign update_o     = r_update;
    assign reject_o     = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_msf_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msf_time_keeper
//  Purpose  : Self-checking bench for msf_time_keeper. A behavioural model
//             (integer hh/mm/ss, converted to BCD) pushes the expected outputs
//             for every driven cycle; they are popped and compared once the
//             DUT has registered that cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_msf_time_keeper;

    localparam int HOLDOVER_MINUTES = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       second_00_i = 1'b0;
    logic       load_i = 1'b0;
    logic [1:0] load_hour_h_i = '0;
    logic [3:0] load_hour_l_i = '0;
    logic [2:0] load_minute_h_i = '0;
    logic [3:0] load_minute_l_i = '0;
    logic [1:0] hour_h_o;
    logic [3:0] hour_l_o;
    logic [2:0] minute_h_o;
    logic [3:0] minute_l_o;
    logic [2:0] second_h_o;
    logic [3:0] second_l_o;
    logic       locked_o;
    logic       holdover_o;
    logic       time_valid_o;
    logic       update_o;
    logic       reject_o;

    msf_time_keeper #(.HOLDOVER_MINUTES(HOLDOVER_MINUTES)) u_dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .tick_i          (tick_i),
        .second_00_i     (second_00_i),
        .load_i          (load_i),
        .load_hour_h_i   (load_hour_h_i),
        .load_hour_l_i   (load_hour_l_i),
        .load_minute_h_i (load_minute_h_i),
        .load_minute_l_i (load_minute_l_i),
        .hour_h_o        (hour_h_o),
        .hour_l_o        (hour_l_o),
        .minute_h_o      (minute_h_o),
        .minute_l_o      (minute_l_o),
        .second_h_o      (second_h_o),
        .second_l_o      (second_l_o),
        .locked_o        (locked_o),
        .holdover_o      (holdover_o),
        .time_valid_o    (time_valid_o),
        .update_o        (update_o),
        .reject_o        (reject_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] t;   // hh_h,hh_l,mm_h,mm_l,ss_h,ss_l
        logic [2:0]  st;  // locked, holdover, valid
        logic [1:0]  sb;  // update, reject
    } exp_t;

    exp_t q_exp[$];
    int   r_checks = 0;
    int   r_errors = 0;

    // Reference model state
    int m_h = 0, m_m = 0, m_s = 0, m_miss = 0, m_st = 0;   // st: 0 UNSYNC 1 LOCKED 2 HOLDOVER

    function automatic logic [19:0] pack_time(input int h, input int m, input int s);
        logic [19:0] r;
        r = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    function automatic logic [19:0] dut_time();
        logic [19:0] r;
        r = {hour_h_o, hour_l_o, minute_h_o, minute_l_o, second_h_o, second_l_o};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit tk, input bit s0, input bit ld,
                         input int lhh, input int lhl, input int lmh, input int lml,
                         output bit upd, output bit rej);
        logic [19:0] old_t;
        bit minute;
        old_t = pack_time(m_h, m_m, m_s);
        upd = 1'b0;
        rej = 1'b0;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_miss = 0; m_st = 0;
        end else if (ld) begin
            if (lhh <= 2 && lhl <= 9 && lmh <= 5 && lml <= 9 && (lhh * 10 + lhl) <= 23) begin
                m_h = lhh * 10 + lhl;
                m_m = lmh * 10 + lml;
                m_s = 0;
                m_miss = 0;
                m_st = 1;
                upd = (pack_time(m_h, m_m, m_s) != old_t);
            end else begin
                rej = 1'b1;
            end
        end else if (tk) begin
            minute = 1'b0;
            if (s0) begin
                minute = (m_s >= 30);
                m_s = 0;
            end else begin
                m_s = m_s + 1;
                if (m_s == 60) begin
                    m_s = 0;
                    minute = 1'b1;
                end
            end
            if (minute) begin
                m_m = m_m + 1;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % 24;
                end
                if (m_miss < 255) m_miss = m_miss + 1;
                if (m_st == 1 && m_miss >= 2) m_st = 2;
                else if (m_st == 2 && m_miss >= HOLDOVER_MINUTES + 1) m_st = 0;
            end
            upd = (pack_time(m_h, m_m, m_s) != old_t);
        end
    endtask

    task automatic cycle(input bit rst, input bit tk, input bit s0, input bit ld,
                         input int lhh = 0, input int lhl = 0, input int lmh = 0, input int lml = 0);
        exp_t e;
        exp_t o;
        bit   upd, rej;
        rst_i           = rst;
        tick_i          = tk;
        second_00_i     = s0;
        load_i          = ld;
        load_hour_h_i   = 2'(lhh);
        load_hour_l_i   = 4'(lhl);
        load_minute_h_i = 3'(lmh);
        load_minute_l_i = 4'(lml);
        model(rst, tk, s0, ld, lhh, lhl, lmh, lml, upd, rej);
        e.t  = pack_time(m_h, m_m, m_s);
        e.st = {m_st == 1, m_st == 2, m_st != 0};
        e.sb = {upd, rej};
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        o = q_exp.pop_front();
        check("time",   32'(dut_time()), 32'(o.t));
        check("status", 32'({locked_o, holdover_o, time_valid_o}), 32'(o.st));
        check("strobe", 32'({update_o, reject_o}), 32'(o.sb));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic marker();
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load(input int hh, input int hl, input int mh, input int ml);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, hh, hl, mh, ml);
    endtask

    task automatic expect_hms(input string tag, input int h, input int m, input int s);
        check(tag, 32'(dut_time()), 32'(pack_time(h, m, s)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", r_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        expect_hms("reset_time", 0, 0, 0);
        check("reset_status", 32'({locked_o, holdover_o, time_valid_o, update_o, reject_o}), 32'd0);
        idle();

        // Load 12:34, run to :59, marker rolls to 12:35:00
        load(1, 2, 3, 4);
        expect_hms("load_1234", 12, 34, 0);
        check("load_lock", 32'({locked_o, time_valid_o, update_o}), 32'b111);
        ticks(59);
        expect_hms("run_1234_59", 12, 34, 59);
        marker();
        expect_hms("marker_1235", 12, 35, 0);
        // Normal following frame: time unchanged, stays locked, no update
        load(1, 2, 3, 5);
        check("follow_frame", 32'({locked_o, holdover_o, update_o}), 32'b100);

        // Day wrap
        load(2, 3, 5, 9);
        ticks(59);
        marker();
        expect_hms("day_wrap", 0, 0, 0);
        // Hour tens carry
        load(0, 9, 5, 9);
        ticks(59);
        marker();
        expect_hms("hour_carry", 10, 0, 0);
        load(1, 0, 0, 0);

        // Leap second: 59 -> 00 on a plain tick, then marker adds nothing
        load(1, 2, 3, 4);
        ticks(59);
        ticks(1);
        expect_hms("leap_roll", 12, 35, 0);
        marker();
        expect_hms("leap_marker", 12, 35, 0);
        check("leap_no_upd", 32'(update_o), 32'd0);
        idle();

        // Rejected loads
        ticks(5);
        load(2, 4, 0, 0);
        check("rej_24h", 32'({reject_o, update_o}), 32'b10);
        expect_hms("rej_24h_time", 12, 35, 5);
        load(1, 2, 3, 10);
        check("rej_minA", 32'(reject_o), 32'd1);
        idle();
        // Valid load wins over a coincident tick
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 0, 8, 0, 0);
        expect_hms("load_over_tick", 8, 0, 0);

        // Holdover then loss of sync
        for (int k = 1; k <= 4; k++) begin
            ticks(59);
            marker();
            if (k == 2) check("holdover_2nd", 32'({locked_o, holdover_o, time_valid_o}), 32'b011);
        end
        check("unsync_4th", 32'({locked_o, holdover_o, time_valid_o}), 32'b000);
        expect_hms("free_run", 8, 4, 0);
        ticks(3);
        load(0, 8, 0, 5);
        check("relock", 32'(locked_o), 32'd1);

        // Reset during HOLDOVER at 07:15:42 with tick and load asserted
        load(0, 7, 1, 3);
        ticks(59); marker();
        ticks(59); marker();
        ticks(42);
        expect_hms("pre_rst", 7, 15, 42);
        check("pre_rst_hold", 32'(holdover_o), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 0, 5);
        expect_hms("rst_time", 0, 0, 0);
        check("rst_flags", 32'({locked_o, holdover_o, time_valid_o, update_o, reject_o}), 32'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msf_time_keeper.md
Name: msf_time_keeper

Overview:
- Local time-of-day controller sitting downstream of the MSF time/date decoder.
- Loads decoded hour/minute when the decoder's valid pulse fires, then runs a BCD hh:mm:ss clock from the 1 Hz second strobe.
- Realigns seconds on each minute marker and absorbs leap seconds.
- Runs a sync-status FSM (UNSYNC / LOCKED / HOLDOVER) so the display layer knows how trustworthy the shown time is.

Parameters:
- HOLDOVER_MINUTES, 60: minute boundaries without a valid frame tolerated in HOLDOVER before falling to UNSYNC; legal range 2..254.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- tick_i  in  1  one-cycle strobe at the start of each received second.
- second_00_i  in  1  qualifies tick_i as the minute marker (second 00); ignored when tick_i=0.
- load_i  in  1  one-cycle decoded-frame valid; arrives 1 cycle after the marker tick.
- load_hour_h_i  in  2  BCD hour tens.
- load_hour_l_i  in  4  BCD hour units.
- load_minute_h_i  in  3  BCD minute tens.
- load_minute_l_i  in  4  BCD minute units.
- hour_h_o  out  2  BCD hour tens.
- hour_l_o  out  4  BCD hour units.
- minute_h_o  out  3  BCD minute tens.
- minute_l_o  out  4  BCD minute units.
- second_h_o  out  3  BCD second tens.
- second_l_o  out  4  BCD second units.
- locked_o  out  1  state==LOCKED.
- holdover_o  out  1  state==HOLDOVER.
- time_valid_o  out  1  state!=UNSYNC.
- update_o  out  1  one-cycle pulse, cycle after any change of the time outputs.
- reject_o  out  1  one-cycle pulse, cycle after a load was discarded as out of range.

Behaviour:
- Reset:
  - All time outputs 0 (00:00:00).
  - State UNSYNC; miss counter 0.
  - update_o, reject_o, locked_o, holdover_o, time_valid_o all 0.
  - Reset wins over every other input in the same cycle.
- All outputs are registered; time and status outputs change on the clock edge where the event is sampled.
- Load range check: accept only if hour tens<=2, hour units<=9, hour value<=23, minute tens<=5, minute units<=9.
  - Rejected load: time, state and counter unchanged; reject_o=1 the next cycle.
- Accepted load:
  - hh:mm := load values; ss := 00.
  - Miss counter := 0; state := LOCKED.
  - update_o pulses.
  - Applies from any state.
  - Takes priority over a coincident tick, which is dropped.
- Tick with second_00_i=0:
  - ss += 1 in BCD; units 9 -> tens+1; 59 -> 00 with a minute event.
- Tick with second_00_i=1 (marker):
  - ss := 00.
  - Minute event only if previous ss >= 30 (BCD tens >= 3).
  - If previous ss < 30 (e.g. after a leap second already rolled at 59->00, or a spurious early marker), no minute event.
- Minute event:
  - mm += 1 in BCD; 59 -> 00 with an hour increment.
  - Hour BCD: units 9 -> tens+1; 23 -> 00. Day wrap is silent.
- Miss counter:
  - 8 bits; +1 on each minute event, saturating at 255; cleared by an accepted load.
- FSM:
  - UNSYNC: the clock still free-runs from ticks. Accepted load -> LOCKED.
  - LOCKED -> HOLDOVER when the miss counter reaches 2.
  - HOLDOVER -> UNSYNC when the miss counter reaches HOLDOVER_MINUTES+1.
  - Accepted load in any state -> LOCKED.
- Status and strobes:
  - The normal marker-then-load sequence (count briefly 1) keeps LOCKED.
  - update_o pulses once per tick or accepted load that alters any time output.
  - update_o and reject_o are never asserted together.

Test Plan:
- Reset then accepted load 12:34 -> outputs 12:34:00, locked_o=1, time_valid_o=1, update_o pulse; 59 ticks -> 12:34:59; marker tick -> 12:35:00.
- Load 23:59, 59 plain ticks then marker -> 00:00:00; load 09:59, run to marker -> 10:00:00.
- Leap second: at 12:34:59 a plain tick -> 12:35:00; following marker tick -> 12:35:00 unchanged, no second minute increment.
- Load 24:00 or minute units=A -> reject_o pulse, outputs and state unchanged; same cycle tick+load(valid) -> load wins, ss=00.
- HOLDOVER_MINUTES=3, lock then withhold loads:
  - 2nd marker -> holdover_o=1.
  - 4th marker -> UNSYNC, time_valid_o=0, clock still counting.
  - Next valid load -> LOCKED.
- Assert rst_i mid-minute while HOLDOVER at 07:15:42 with tick and load high -> 00:00:00, UNSYNC, all strobes 0.
